// File: rtl/systolic_row_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// Package : systolic_pkg
// Brief   : Shared run-state encoding and default array geometry.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package systolic_pkg;

    localparam int C_ARRAY_SIZE = 9;
    localparam int C_CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        RAMP_UP   = 3'd2,
        HOLD      = 3'd3,
        RAMP_DOWN = 3'd4,
        DONE      = 3'd5
    } seq_state_e;

    function automatic logic is_busy(input seq_state_e st);
        return (st inside {LOAD, RAMP_UP, HOLD, RAMP_DOWN});
    endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_row_sequencer_if.sv
// ---------------------------------------------------------------------------
// Interface : systolic_row_sequencer_if
// Brief     : Scheduler-side run request and array-side control bundle.
// Rev       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface systolic_row_sequencer_if
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = C_ARRAY_SIZE,
    parameter int CNT_W      = C_CNT_W
) ();

    logic                  clear;
    logic                  enable;
    logic                  start;
    logic [CNT_W-1:0]      load_cycles;
    logic [CNT_W-1:0]      compute_cycles;
    logic                  drain_en;
    logic                  w_load;
    logic [ARRAY_SIZE-1:0] r_en;
    logic                  s_reset;
    logic                  busy;
    logic                  done;

    modport master (
        output clear, enable, start, load_cycles, compute_cycles, drain_en,
        input  w_load, r_en, s_reset, busy, done
    );

    modport slave (
        input  clear, enable, start, load_cycles, compute_cycles, drain_en,
        output w_load, r_en, s_reset, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/systolic_row_sequencer_row_stagger.sv
// ---------------------------------------------------------------------------
// Module : row_stagger_reg
// Brief  : Per-row enable shift register with STEP_CYCLES step prescaler.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module row_stagger_reg #(
    parameter int ARRAY_SIZE  = 9,
    parameter int STEP_CYCLES = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  clr,
    input  wire logic                  seed,
    input  wire logic                  drain_seed,
    input  wire logic                  step_en,
    input  wire logic                  fill,
    output logic [ARRAY_SIZE-1:0]      rows,
    output logic                       last_step
);

    localparam int             PW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0]  C_PRE_MAX = PW'(STEP_CYCLES - 1);

    logic [PW-1:0]         r_pre;
    logic [ARRAY_SIZE-1:0] r_rows;
    logic                  w_step;

    assign w_step = step_en && (r_pre == C_PRE_MAX);
    assign rows   = r_rows;

    // Prescaler restarts on every pattern load so the first step is a full period away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clr || seed || drain_seed) begin
            r_pre <= '0;
        end else if (step_en) begin
            r_pre <= w_step ? '0 : r_pre + PW'(1);
        end
    end

    generate
        if (ARRAY_SIZE == 1) begin : g_single
            logic w_unused;
            assign w_unused  = fill;
            assign last_step = w_step;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rows <= '0;
                end else if (clr || drain_seed) begin
                    r_rows <= '0;
                end else if (seed) begin
                    r_rows <= 1'b1;
                end
            end
        end else begin : g_multi
            // Final step: all lower rows already on (fill) or already off (drain)
            assign last_step = w_step && (fill ? (&r_rows[ARRAY_SIZE-2:0])
                                               : ~(|r_rows[ARRAY_SIZE-2:0]));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rows <= '0;
                end else if (clr) begin
                    r_rows <= '0;
                end else if (seed) begin
                    r_rows <= ARRAY_SIZE'(1);
                end else if (drain_seed) begin
                    r_rows <= {{(ARRAY_SIZE-1){1'b1}}, 1'b0};
                end else if (w_step) begin
                    r_rows <= {r_rows[ARRAY_SIZE-2:0], fill};
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/systolic_row_sequencer.sv
// ---------------------------------------------------------------------------
// Module : systolic_row_sequencer
// Brief  : Run controller: weight load, row ramp-up, hold, optional drain, done.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_row_sequencer
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE  = C_ARRAY_SIZE,
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = C_CNT_W
) (
    input  wire logic               s_clk,
    input  wire logic               reset,
    systolic_row_sequencer_if.slave bus
);

    // A single-row array has no ramp phases to walk through
    localparam seq_state_e C_FILL_DEST  = (ARRAY_SIZE == 1) ? HOLD : RAMP_UP;
    localparam seq_state_e C_DRAIN_DEST = (ARRAY_SIZE == 1) ? DONE : RAMP_DOWN;

    seq_state_e            r_state;
    seq_state_e            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      r_comp_len;
    logic [CNT_W-1:0]      w_comp_in;
    logic                  r_drain;
    logic                  w_latch;
    logic                  w_seed;
    logic                  w_drain_seed;
    logic                  w_step_en;
    logic                  w_fill;
    logic                  w_clr_rows;
    logic                  w_last_step;
    logic [ARRAY_SIZE-1:0] w_rows;
    logic                  r_w_load;
    logic                  r_s_reset;
    logic                  r_busy;
    logic                  r_done;

    assign w_comp_in = (bus.compute_cycles == '0) ? CNT_W'(1) : bus.compute_cycles;

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_seed       = 1'b0;
        w_drain_seed = 1'b0;
        w_step_en    = 1'b0;
        w_fill       = 1'b1;
        w_clr_rows   = 1'b0;

        if (bus.clear) begin
            w_next     = IDLE;
            w_cnt_next = '0;
            w_clr_rows = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && bus.enable) begin
                        w_latch = 1'b1;
                        if (bus.load_cycles != '0) begin
                            w_next     = LOAD;
                            w_cnt_next = bus.load_cycles;
                        end else begin
                            w_seed     = 1'b1;
                            w_next     = C_FILL_DEST;
                            w_cnt_next = (ARRAY_SIZE == 1) ? w_comp_in : '0;
                        end
                    end
                end
                LOAD: begin
                    if (bus.enable) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_seed     = 1'b1;
                            w_next     = C_FILL_DEST;
                            w_cnt_next = (ARRAY_SIZE == 1) ? r_comp_len : '0;
                        end else begin
                            w_cnt_next = r_cnt - CNT_W'(1);
                        end
                    end
                end
                RAMP_UP: begin
                    if (bus.enable) begin
                        w_step_en = 1'b1;
                        if (w_last_step) begin
                            w_next     = HOLD;
                            w_cnt_next = r_comp_len;
                        end
                    end
                end
                HOLD: begin
                    if (bus.enable) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_cnt_next = '0;
                            if (r_drain) begin
                                w_drain_seed = 1'b1;
                                w_next       = C_DRAIN_DEST;
                            end else begin
                                w_clr_rows = 1'b1;
                                w_next     = DONE;
                            end
                        end else begin
                            w_cnt_next = r_cnt - CNT_W'(1);
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (bus.enable) begin
                        w_step_en = 1'b1;
                        w_fill    = 1'b0;
                        if (w_last_step) begin
                            w_next = DONE;
                        end
                    end
                end
                DONE: begin
                    w_next     = IDLE;
                    w_clr_rows = 1'b1;
                end
                default: begin
                    w_next     = IDLE;
                    w_clr_rows = 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_en
    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_comp_len <= '0;
            r_drain    <= 1'b0;
            r_w_load   <= 1'b0;
            r_s_reset  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_w_load <= (w_next == LOAD);
            r_busy   <= is_busy(w_next);
            r_done   <= (w_next == DONE);
            if (w_latch) begin
                r_comp_len <= w_comp_in;
                r_drain    <= bus.drain_en;
            end
            if (bus.clear || (w_next == LOAD)) begin
                r_s_reset <= 1'b0;
            end else if (w_next != IDLE) begin
                r_s_reset <= 1'b1;
            end
        end
    end

    row_stagger_reg #(
        .ARRAY_SIZE  (ARRAY_SIZE),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_rows (
        .clk        (s_clk),
        .rst_n      (reset),
        .clr        (w_clr_rows),
        .seed       (w_seed),
        .drain_seed (w_drain_seed),
        .step_en    (w_step_en),
        .fill       (w_fill),
        .rows       (w_rows),
        .last_step  (w_last_step)
    );

    assign bus.w_load  = r_w_load;
    assign bus.r_en    = w_rows;
    assign bus.s_reset = r_s_reset;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_systolic_row_sequencer.sv
// ---------------------------------------------------------------------------
// Module : tb_systolic_row_sequencer
// Brief  : Three array geometries driven in parallel against a phase-list model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_systolic_row_sequencer;

    logic        s_clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        enable;
    logic        start;
    logic [15:0] load_len;
    logic [15:0] comp_len;
    logic        drain;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cc       = 0;

    always #5 s_clk = ~s_clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int N = (g == 0) ? 4 : ((g == 1) ? 9 : 1);
            localparam int S = (g == 0) ? 2 : 1;
            localparam int W = N + 4;

            systolic_row_sequencer_if #(.ARRAY_SIZE(N), .CNT_W(16)) u_if ();

            assign u_if.clear          = clear;
            assign u_if.enable         = enable;
            assign u_if.start          = start;
            assign u_if.load_cycles    = load_len;
            assign u_if.compute_cycles = comp_len;
            assign u_if.drain_en       = drain;

            systolic_row_sequencer #(
                .ARRAY_SIZE  (N),
                .STEP_CYCLES (S),
                .CNT_W       (16)
            ) u_dut (
                .s_clk (s_clk),
                .reset (reset),
                .bus   (u_if)
            );

            // Expected output vector packed as {w_load, s_reset, busy, done, r_en}
            logic [W-1:0] cur = '0;
            logic [W-1:0] q[$];

            function automatic logic [W-1:0] mk(input logic w, input logic s, input logic b,
                                                input logic d, input logic [N-1:0] r);
                return {w, s, b, d, r};
            endfunction

            // The run is a list of per-enabled-cycle output vectors; frozen cycles repeat one
            always @(posedge s_clk) begin
                if (!reset || clear) begin
                    cur = '0;
                    q.delete();
                end else if (cur[N+1]) begin
                    if (enable) cur = q.pop_front();
                end else if (cur[N]) begin
                    cur = mk(1'b0, cur[N+2], 1'b0, 1'b0, '0);
                end else if (start && enable) begin
                    logic [N-1:0] r;
                    int           hl;
                    hl = (comp_len == 16'd0) ? 1 : int'(comp_len);
                    for (int i = 0; i < int'(load_len); i++) q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0));
                    for (int i = 1; i < N; i++) begin
                        r = {N{1'b1}} >> (N - i);
                        for (int k = 0; k < S; k++) q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, r));
                    end
                    for (int i = 0; i < hl; i++) q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, {N{1'b1}}));
                    if (drain) begin
                        for (int i = 1; i < N; i++) begin
                            r = {N{1'b1}} << i;
                            for (int k = 0; k < S; k++) q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, r));
                        end
                    end
                    q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, '0));
                    cur = q.pop_front();
                end
            end

            always @(posedge s_clk) begin
                logic [W-1:0] act;
                #2;
                act = {u_if.w_load, u_if.s_reset, u_if.busy, u_if.done, u_if.r_en};
                n_checks++;
                if (act !== cur) begin
                    n_fail++;
                    $display("FAIL model_cmp dut%0d t=%0t actual=%h required=%h", g, $time, act, cur);
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic adv(input int to);
        while (cc < to) begin
            @(negedge s_clk);
            cc++;
        end
    endtask

    // Start sampled on the next edge; returns at the negedge of cycle 1
    task automatic launch(input int l, input int c, input logic d);
        load_len = 16'(l);
        comp_len = 16'(c);
        drain    = d;
        start    = 1'b1;
        @(negedge s_clk);
        start    = 1'b0;
        load_len = 16'd7;
        comp_len = 16'd0;
        drain    = ~d;
        cc       = 1;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while ((g_dut[0].u_if.busy || g_dut[0].u_if.done || g_dut[1].u_if.busy ||
                g_dut[1].u_if.done || g_dut[2].u_if.busy || g_dut[2].u_if.done) && i < 400) begin
            @(negedge s_clk);
            i++;
        end
        n_checks++;
        if (i >= 400) begin
            n_fail++;
            $display("FAIL %s timeout actual=busy required=idle", name);
        end
        @(negedge s_clk);
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        enable   = 1'b1;
        start    = 1'b0;
        load_len = '0;
        comp_len = '0;
        drain    = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge s_clk);
        chk("rst_r_en",    32'(g_dut[0].u_if.r_en),    0);
        chk("rst_busy",    32'(g_dut[0].u_if.busy),    0);
        chk("rst_s_reset", 32'(g_dut[0].u_if.s_reset), 0);
        chk("rst_w_load",  32'(g_dut[0].u_if.w_load),  0);
        chk("rst_done",    32'(g_dut[0].u_if.done),    0);
        reset = 1'b1;
        @(negedge s_clk);

        // N=4 S=2 L=3 C=5 with drain, plus an ignored start while busy
        launch(3, 5, 1'b1);
        chk("t1_wload_c1", 32'(g_dut[0].u_if.w_load), 1);
        adv(3);  chk("t1_wload_c3", 32'(g_dut[0].u_if.w_load), 1);
        adv(4);  chk("t1_wload_c4", 32'(g_dut[0].u_if.w_load), 0);
                 chk("t1_ren_c4",   32'(g_dut[0].u_if.r_en),   4'h1);
        adv(5);  start = 1'b1;
        adv(6);  start = 1'b0;
                 chk("t1_ren_c6",   32'(g_dut[0].u_if.r_en),   4'h3);
        adv(10); chk("t1_ren_c10",  32'(g_dut[0].u_if.r_en),   4'hF);
        adv(14); chk("t1_ren_c14",  32'(g_dut[0].u_if.r_en),   4'hF);
        adv(15); chk("t1_ren_c15",  32'(g_dut[0].u_if.r_en),   4'hE);
        adv(20); chk("t1_ren_c20",  32'(g_dut[0].u_if.r_en),   4'h8);
                 chk("t1_busy_c20", 32'(g_dut[0].u_if.busy),   1);
        adv(21); chk("t1_done_c21", 32'(g_dut[0].u_if.done),   1);
                 chk("t1_ren_c21",  32'(g_dut[0].u_if.r_en),   0);
                 chk("t1_busy_c21", 32'(g_dut[0].u_if.busy),   0);
        adv(22); chk("t1_done_c22", 32'(g_dut[0].u_if.done),   0);
                 chk("t1_srst_c22", 32'(g_dut[0].u_if.s_reset), 1);
        wait_idle("t1_idle");

        // Same run without drain
        launch(3, 5, 1'b0);
        chk("t2_srst_c1", 32'(g_dut[0].u_if.s_reset), 0);
        adv(14); chk("t2_ren_c14",  32'(g_dut[0].u_if.r_en), 4'hF);
        adv(15); chk("t2_done_c15", 32'(g_dut[0].u_if.done), 1);
                 chk("t2_ren_c15",  32'(g_dut[0].u_if.r_en), 0);
        adv(18); chk("t2_srst_c18", 32'(g_dut[0].u_if.s_reset), 1);
        wait_idle("t2_idle");

        // No load window, single compute cycle; N=9 walks one row per cycle
        launch(0, 1, 1'b0);
        chk("t3_n9_ren_c1",  32'(g_dut[1].u_if.r_en),   9'h001);
        chk("t3_n9_wld_c1",  32'(g_dut[1].u_if.w_load), 0);
        chk("t3_n1_ren_c1",  32'(g_dut[2].u_if.r_en),   1);
        adv(2);  chk("t3_n1_done_c2", 32'(g_dut[2].u_if.done), 1);
        adv(8);  chk("t3_n9_ren_c8",  32'(g_dut[1].u_if.r_en), 9'h0FF);
        adv(9);  chk("t3_n9_ren_c9",  32'(g_dut[1].u_if.r_en), 9'h1FF);
        adv(10); chk("t3_n9_done_c10", 32'(g_dut[1].u_if.done), 1);
                 chk("t3_n9_ren_c10",  32'(g_dut[1].u_if.r_en), 0);
        wait_idle("t3_idle");

        // Four frozen edges during the 0011 step
        launch(3, 5, 1'b1);
        adv(6);  chk("t4_ren_c6", 32'(g_dut[0].u_if.r_en), 4'h3);
                 enable = 1'b0;
        adv(9);  chk("t4_ren_c9",  32'(g_dut[0].u_if.r_en), 4'h3);
                 chk("t4_busy_c9", 32'(g_dut[0].u_if.busy), 1);
        adv(10); enable = 1'b1;
                 chk("t4_ren_c10", 32'(g_dut[0].u_if.r_en), 4'h3);
        adv(12); chk("t4_ren_c12", 32'(g_dut[0].u_if.r_en), 4'h7);
        adv(24); chk("t4_done_c24", 32'(g_dut[0].u_if.done), 0);
        adv(25); chk("t4_done_c25", 32'(g_dut[0].u_if.done), 1);
        wait_idle("t4_idle");

        // Clear during HOLD, then clear together with start
        launch(3, 5, 1'b1);
        adv(12); clear = 1'b1;
        adv(13); clear = 1'b0;
                 chk("t5_ren_c13",  32'(g_dut[0].u_if.r_en),    0);
                 chk("t5_srst_c13", 32'(g_dut[0].u_if.s_reset), 0);
                 chk("t5_busy_c13", 32'(g_dut[0].u_if.busy),    0);
        adv(22); chk("t5_done_c22", 32'(g_dut[0].u_if.done),    0);
        load_len = 16'd3;
        comp_len = 16'd5;
        clear    = 1'b1;
        start    = 1'b1;
        @(negedge s_clk);
        clear = 1'b0;
        start = 1'b0;
        chk("t5_cs_busy", 32'(g_dut[0].u_if.busy), 0);
        @(negedge s_clk);
        chk("t5_cs_busy2", 32'(g_dut[0].u_if.busy), 0);
        chk("t5_cs_wload", 32'(g_dut[0].u_if.w_load), 0);
        wait_idle("t5_idle");

        // Asynchronous reset mid drain, then a normal run
        launch(3, 5, 1'b1);
        adv(16); chk("t6_ren_c16", 32'(g_dut[0].u_if.r_en), 4'hE);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_ren",  32'(g_dut[0].u_if.r_en),    0);
        chk("t6_async_busy", 32'(g_dut[0].u_if.busy),    0);
        chk("t6_async_srst", 32'(g_dut[0].u_if.s_reset), 0);
        adv(18); reset = 1'b1;
        adv(19);
        launch(0, 1, 1'b0);
        chk("t6_rerun_ren",  32'(g_dut[0].u_if.r_en),    4'h1);
        chk("t6_rerun_srst", 32'(g_dut[0].u_if.s_reset), 1);
        wait_idle("t6_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/systolic_row_sequencer.md
Name: systolic_row_sequencer

Overview:
Run controller for the weight-stationary systolic MAC array. It replaces the hand-stepped row enable used in bring-up with a parametrised sequence: weight load window, staggered row ramp-up, full-array compute hold, optional staggered drain, then a one-cycle done. It sits between the layer scheduler (start/lengths) and the array (w_load, r_en, s_reset).

Parameters:
ARRAY_SIZE, 9, number of array rows; width of r_en
STEP_CYCLES, 1, enabled cycles between successive row-enable steps (>=1)
CNT_W, 16, width of the load and compute length counters

Ports:
s_clk  input  1  sole clock
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort; returns to IDLE
enable  input  1  advance qualifier; low freezes an active run
start  input  1  begin a run (sampled in IDLE only)
load_cycles  input  CNT_W  weight-load window length, sampled at start
compute_cycles  input  CNT_W  full-array hold length, sampled at start (0 treated as 1)
drain_en  input  1  staggered ramp-down select, sampled at start
w_load  output  1  weight-load strobe to array
r_en  output  ARRAY_SIZE  per-row enable, bit 0 = first row
s_reset  output  1  array accumulator reset, active-low
busy  output  1  high in LOAD, RAMP_UP, HOLD, RAMP_DOWN
done  output  1  one-cycle end-of-run pulse

Behaviour:
- Reset: state IDLE, r_en=0, w_load=0, s_reset=0, busy=0, done=0, all counters 0. All outputs are registered.
- IDLE: start&enable -> latch lengths/drain_en; if load_cycles!=0 go LOAD, else go RAMP_UP with r_en<=1 on the same edge. start without enable is ignored.
- LOAD: w_load=1, s_reset=0, exactly load_cycles enabled cycles; on the last, r_en<=1, s_reset<=1, w_load<=0, go RAMP_UP.
- RAMP_UP: every STEP_CYCLES enabled cycles, r_en<={r_en[N-2:0],1}. The step that makes r_en all-ones also moves to HOLD. Duration (ARRAY_SIZE-1)*STEP_CYCLES cycles.
- HOLD: r_en all-ones for exactly max(compute_cycles,1) enabled cycles. On the last cycle: drain_en -> r_en<={all-ones[N-2:0],0}, go RAMP_DOWN; else r_en<=0, go DONE.
- RAMP_DOWN: every STEP_CYCLES, r_en<={r_en[N-2:0],0}. The step reaching 0 goes to DONE. Duration (ARRAY_SIZE-1)*STEP_CYCLES cycles.
- DONE: done=1, busy=0, r_en=0 for one cycle, then IDLE unconditionally. Not gated by enable.
- s_reset stays 1 from RAMP_UP entry through DONE/IDLE so results stay readable. It is driven to 0 only in LOAD, after clear, and at reset.
- enable low in LOAD/RAMP_UP/HOLD/RAMP_DOWN: state, step counter, length counter and all outputs hold.
- clear: highest priority after reset. Next edge gives IDLE, r_en=0, w_load=0, s_reset=0, busy=0, done=0; no done pulse. clear together with start: clear wins.
- start while busy or in DONE is ignored. Length ports may change freely after sampling.
- ARRAY_SIZE=1: RAMP_UP and RAMP_DOWN take 0 cycles (go straight to HOLD / DONE).

Decomposition:
- Package systolic_pkg: state enum (IDLE, LOAD, RAMP_UP, HOLD, RAMP_DOWN, DONE) and the default ARRAY_SIZE/CNT_W constants, shared with the array top.
- One sub-module, row_stagger_reg: the ARRAY_SIZE-wide shift register with fill-one/shift-zero/clear controls and its STEP_CYCLES prescaler. The FSM and length counters stay in the parent.

Test Plan:
- N=4,S=2,L=3,C=5,drain=1, start at edge 0 -> w_load high cycles 1-3; r_en 0001@4-5, 0011@6-7, 0111@8-9, 1111@10-14, 1110@15-16, 1100@17-18, 1000@19-20; done=1, r_en=0 @21; busy low @21.
- Same with drain=0 -> r_en 1111@10-14; done @15 with r_en=0000; s_reset stays 1 after.
- N=9,S=1,L=0,C=1 -> r_en=0x001 the cycle after start, one new row per cycle to 0x1FF, 0x1FF for exactly 1 cycle; w_load never asserts.
- enable low for 4 cycles while r_en=0011 (N=4,S=2) -> r_en, busy and timing hold; sequence resumes and done is 4 cycles late.
- clear asserted in HOLD (and clear+start in IDLE) -> next edge r_en=0, s_reset=0, busy=0, no done pulse; start is ignored.
- reset asserted mid RAMP_DOWN, asynchronously between edges -> all outputs 0 immediately; after release, IDLE, and a new start runs normally.
